// File: rtl/hexbs_mb_scheduler.sv
// Walks hexbs_top over every macroblock of a frame range in raster order and
// forwards each {frame,row,col,mv,sad} result on a valid/ready port.
module hexbs_mb_scheduler #(
  parameter int FRAME_WIDTH  = 352,
  parameter int FRAME_HEIGHT = 240,
  parameter int MB_SIZE      = 16,
  parameter int ADDR_W       = 32,
  parameter int TIMEOUT      = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [15:0]       cfg_first_frame,
  input  logic [15:0]       cfg_num_frames,
  output logic              busy,
  output logic              seq_done,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic              me_start,
  output logic [ADDR_W-1:0] me_frame_addr,
  output logic [ADDR_W-1:0] me_ref_addr,
  output logic [31:0]       me_mb_x,
  output logic [31:0]       me_mb_y,
  input  logic              me_done,
  input  logic [5:0]        me_mv_x,
  input  logic [5:0]        me_mv_y,
  input  logic [15:0]       me_sad,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_frame,
  output logic [7:0]        res_mb_row,
  output logic [7:0]        res_mb_col,
  output logic [5:0]        res_mv_x,
  output logic [5:0]        res_mv_y,
  output logic [15:0]       res_sad
);

  localparam int MB_COLS    = FRAME_WIDTH / MB_SIZE;
  localparam int MB_ROWS    = FRAME_HEIGHT / MB_SIZE;
  localparam int FRAME_SIZE = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int WD_W       = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] FRAME_SIZE_V = ADDR_W'(FRAME_SIZE);
  localparam logic [7:0]        COL_LAST     = 8'(MB_COLS - 1);
  localparam logic [7:0]        ROW_LAST     = 8'(MB_ROWS - 1);
  localparam logic [WD_W-1:0]   WD_LOAD      = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_PUSH, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       frame_q, frame_d, last_q, last_d;
  logic [7:0]        row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d, raddr_q, raddr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_cfg_q, err_cfg_d, err_to_q, err_to_d, rej_q, rej_d;
  logic [15:0]       rframe_q, rframe_d, rsad_q, rsad_d;
  logic [7:0]        rrow_q, rrow_d, rcol_q, rcol_d;
  logic [5:0]        rmvx_q, rmvx_d, rmvy_q, rmvy_d;

  // Constant shift-add: only the set bits of FRAME_SIZE contribute an adder.
  function automatic logic [ADDR_W-1:0] frame_base(input logic [15:0] f);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] fx;
    acc = '0;
    fx  = ADDR_W'(f);
    for (int i = 0; i < ADDR_W; i++)
      if (FRAME_SIZE_V[i]) acc = acc + (fx << i);
    return acc;
  endfunction

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    last_d    = last_q;
    row_d     = row_q;
    col_d     = col_q;
    faddr_d   = faddr_q;
    raddr_d   = raddr_q;
    wd_d      = wd_q;
    err_cfg_d = err_cfg_q;
    err_to_d  = err_to_q;
    rej_d     = 1'b0;
    rframe_d  = rframe_q;
    rrow_d    = rrow_q;
    rcol_d    = rcol_q;
    rmvx_d    = rmvx_q;
    rmvy_d    = rmvy_q;
    rsad_d    = rsad_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_first_frame == 16'd0 || cfg_num_frames == 16'd0) begin
            err_cfg_d = 1'b1;
            rej_d     = 1'b1;
          end else begin
            frame_d  = cfg_first_frame;
            last_d   = cfg_first_frame + cfg_num_frames - 16'd1;
            row_d    = '0;
            col_d    = '0;
            faddr_d  = frame_base(cfg_first_frame);
            raddr_d  = frame_base(cfg_first_frame) - FRAME_SIZE_V;
            err_to_d = 1'b0;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = WD_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // wd_q == WD_LOAD marks the first WAIT cycle, where done may be stale
        if (me_done && wd_q != WD_LOAD) begin
          rframe_d = frame_q;
          rrow_d   = row_q;
          rcol_d   = col_q;
          rmvx_d   = me_mv_x;
          rmvy_d   = me_mv_y;
          rsad_d   = me_sad;
          state_d  = S_PUSH;
        end else if (wd_q == '0) begin
          err_to_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      S_PUSH: begin
        if (res_ready) begin
          state_d = S_ISSUE;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d = '0;
              if (frame_q == last_q) begin
                state_d = S_DONE;
              end else begin
                frame_d = frame_q + 16'd1;
                faddr_d = faddr_q + FRAME_SIZE_V;
                raddr_d = raddr_q + FRAME_SIZE_V;
              end
            end else begin
              row_d = row_q + 8'd1;
            end
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      last_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      faddr_q   <= '0;
      raddr_q   <= '0;
      wd_q      <= '0;
      err_cfg_q <= 1'b0;
      err_to_q  <= 1'b0;
      rej_q     <= 1'b0;
      rframe_q  <= '0;
      rrow_q    <= '0;
      rcol_q    <= '0;
      rmvx_q    <= '0;
      rmvy_q    <= '0;
      rsad_q    <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      row_q     <= row_d;
      col_q     <= col_d;
      faddr_q   <= faddr_d;
      raddr_q   <= raddr_d;
      wd_q      <= wd_d;
      err_cfg_q <= err_cfg_d;
      err_to_q  <= err_to_d;
      rej_q     <= rej_d;
      rframe_q  <= rframe_d;
      rrow_q    <= rrow_d;
      rcol_q    <= rcol_d;
      rmvx_q    <= rmvx_d;
      rmvy_q    <= rmvy_d;
      rsad_q    <= rsad_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign seq_done      = (state_q == S_DONE) | rej_q;
  assign err_cfg       = err_cfg_q;
  assign err_timeout   = err_to_q;
  assign me_start      = (state_q == S_ISSUE);
  assign me_frame_addr = faddr_q;
  assign me_ref_addr   = raddr_q;
  assign me_mb_x       = {24'd0, col_q};
  assign me_mb_y       = {24'd0, row_q};
  assign res_valid     = (state_q == S_PUSH);
  assign res_frame     = rframe_q;
  assign res_mb_row    = rrow_q;
  assign res_mb_col    = rcol_q;
  assign res_mv_x      = rmvx_q;
  assign res_mv_y      = rmvy_q;
  assign res_sad       = rsad_q;

endmodule

// File: tb/tb_hexbs_mb_scheduler.sv
// Directed bench for hexbs_mb_scheduler with a behavioural hexbs_top stand-in
// whose done stays high (stale) into the next start.
module tb_hexbs_mb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [15:0] cfg_first_frame, cfg_num_frames;
  logic        busy, seq_done, err_cfg, err_timeout, me_start;
  logic [31:0] me_frame_addr, me_ref_addr, me_mb_x, me_mb_y;
  logic        me_done;
  logic [5:0]  me_mv_x, me_mv_y;
  logic [15:0] me_sad;
  logic        res_valid, res_ready;
  logic [15:0] res_frame;
  logic [7:0]  res_mb_row, res_mb_col;
  logic [5:0]  res_mv_x, res_mv_y;
  logic [15:0] res_sad;

  always #5 clk = ~clk;

  hexbs_mb_scheduler dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_first_frame(cfg_first_frame), .cfg_num_frames(cfg_num_frames),
    .busy(busy), .seq_done(seq_done), .err_cfg(err_cfg), .err_timeout(err_timeout),
    .me_start(me_start), .me_frame_addr(me_frame_addr), .me_ref_addr(me_ref_addr),
    .me_mb_x(me_mb_x), .me_mb_y(me_mb_y), .me_done(me_done),
    .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_sad(me_sad),
    .res_valid(res_valid), .res_ready(res_ready), .res_frame(res_frame),
    .res_mb_row(res_mb_row), .res_mb_col(res_mb_col),
    .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_sad(res_sad)
  );

  localparam int FSZ = 84480;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_res(input int f, input int r, input int c);
    logic [5:0]  mx, my;
    logic [15:0] sd;
    mx = 6'(c - 11);
    my = 6'(r - 7);
    sd = 16'(f * 97 + r * 23 + c);
    return {4'd0, 16'(f), 8'(r), 8'(c), mx, my, sd};
  endfunction

  function automatic logic [63:0] dut_res();
    return {4'd0, res_frame, res_mb_row, res_mb_col, res_mv_x, res_mv_y, res_sad};
  endfunction

  // engine stand-in: done held from previous MB until one cycle after start
  int lat = 20;
  bit eng_hang = 0;
  bit eng_pend;
  int eng_cnt;
  int ef, ex, ey;

  initial begin
    me_done = 1'b0; me_mv_x = '0; me_mv_y = '0; me_sad = '0;
    eng_pend = 0; eng_cnt = 0;
  end

  always @(negedge clk) begin
    if (rst) begin
      me_done = 1'b0; eng_pend = 0; eng_cnt = 0;
    end else if (me_start) begin
      eng_pend = 1;
      ef = int'(me_frame_addr) / FSZ;
      ex = int'(me_mb_x);
      ey = int'(me_mb_y);
    end else if (eng_pend) begin
      eng_pend = 0;
      me_done  = 1'b0;
      eng_cnt  = lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_hang) begin
        logic [63:0] p;
        p = pack_res(ef, ey, ex);
        me_mv_x = p[27:22];
        me_mv_y = p[21:16];
        me_sad  = p[15:0];
        me_done = 1'b1;
      end
    end
  end

  // raster monitor
  bit mon_en = 0;
  int exp_f, exp_r, exp_c, nres, nsd;

  always @(negedge clk) begin
    if (seq_done) nsd++;
    if (mon_en) begin
      if (me_start) begin
        check("frame_addr", 64'(me_frame_addr), 64'(exp_f * FSZ));
        check("ref_addr", 64'(me_ref_addr), 64'((exp_f - 1) * FSZ));
        check("mb_xy", {me_mb_y, me_mb_x}, {32'(exp_r), 32'(exp_c)});
      end
      if (res_valid && res_ready) begin
        check("result", dut_res(), pack_res(exp_f, exp_r, exp_c));
        nres++;
        exp_c++;
        if (exp_c == 22) begin
          exp_c = 0; exp_r++;
          if (exp_r == 15) begin exp_r = 0; exp_f++; end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int first, input int num);
    cfg_first_frame = 16'(first);
    cfg_num_frames  = 16'(num);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_seq(input int budget, input string tag);
    int k = 0;
    while (!seq_done && k < budget) begin @(negedge clk); k++; end
    check(tag, 64'(seq_done), 64'd1);
  endtask

  task automatic mon_arm(input int f);
    exp_f = f; exp_r = 0; exp_c = 0; nres = 0; nsd = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 64'({busy, seq_done, err_cfg, err_timeout, me_start, res_valid}), 64'd0);
    check({tag, "_addr"}, {me_frame_addr, me_ref_addr}, 64'd0);
    check({tag, "_mb"}, {me_mb_y, me_mb_x}, 64'd0);
    check({tag, "_res"}, dut_res(), 64'd0);
  endtask

  initial begin
    logic [63:0] snap;
    int k;
    bit saw_valid;
    rst = 1'b1; cfg_start = 1'b0; cfg_first_frame = '0; cfg_num_frames = '0;
    res_ready = 1'b1;
    cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    cyc(2);

    // one frame, 20-cycle engine
    lat = 20; mon_arm(1); mon_en = 1;
    start(1, 1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_seq(20000, "t1_seq_done");
    cyc(1);
    check("t1_busy_off", 64'(busy), 64'd0);
    check("t1_count", 64'(nres), 64'd330);
    check("t1_nsd", 64'(nsd), 64'd1);
    check("t1_end_pos", 64'({exp_f, exp_r, exp_c}), 64'({32'd2, 32'd0, 32'd0}));
    check("t1_last", dut_res(), pack_res(1, 14, 21));

    // two frames, short engine, ignored restart mid-run
    lat = 2; mon_arm(3);
    start(3, 2);
    cyc(50);
    start(9, 1);
    check("t2_busy_ign", 64'(busy), 64'd1);
    wait_seq(20000, "t2_seq_done");
    cyc(1);
    check("t2_count", 64'(nres), 64'd660);
    check("t2_nsd", 64'(nsd), 64'd1);
    check("t2_end_frame", 64'(exp_f), 64'd5);

    // backpressure then reset during WAIT
    mon_en = 0; res_ready = 1'b0; lat = 5;
    start(5, 1);
    k = 0;
    while (!res_valid && k < 100) begin cyc(1); k++; end
    check("bp_valid", 64'(res_valid), 64'd1);
    snap = dut_res();
    check("bp_first", snap, pack_res(5, 0, 0));
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("bp_hold", dut_res(), snap);
      check("bp_nostart", 64'({me_start, res_valid}), 64'b01);
    end
    res_ready = 1'b1;
    cyc(1);
    res_ready = 1'b0;
    check("bp_next_issue", {me_start ? 32'd1 : 32'd0, me_mb_x}, {32'd1, 32'd1});
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check_all_zero("rst_mid");
    rst = 1'b0;
    cyc(1);
    res_ready = 1'b1; mon_arm(7); mon_en = 1;
    start(7, 1);
    k = 0;
    while (nres < 2 && k < 200) begin cyc(1); k++; end
    check("restart_nres", 64'(nres), 64'd2);
    mon_en = 0;
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);

    // rejected configurations
    start(0, 4);
    check("cfg0_pulse", 64'({err_cfg, seq_done, busy, me_start}), 64'b1100);
    cyc(1);
    check("cfg0_sticky", 64'({err_cfg, seq_done, busy, me_start}), 64'b1000);
    start(2, 0);
    check("num0_pulse", 64'({err_cfg, seq_done, busy, me_start}), 64'b1100);
    cyc(1);

    // engine never completes
    eng_hang = 1; saw_valid = 0;
    start(1, 1);
    check("to_start", 64'(me_start), 64'd1);
    k = 0;
    while (!seq_done && k < 60000) begin
      cyc(1); k++;
      if (res_valid) saw_valid = 1;
    end
    check("to_cycles", 64'(k), 64'd50001);
    check("to_err", 64'({err_timeout, saw_valid}), 64'b10);
    cyc(1);
    check("to_after", 64'({busy, seq_done, err_timeout}), 64'b001);
    eng_hang = 0;
    start(1, 1);
    check("to_cleared", 64'({err_timeout, busy}), 64'b01);
    rst = 1'b1; cyc(2); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
